// File: rtl/log2_lms_if.sv
// Beat handshake bundle for log2_lms_pipe: the input beat side (i_valid/o_ready/i_data)
// and the output beat side (o_valid/i_ready/o_log2/o_zero).
interface log2_lms_if #(
  parameter int CH    = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = 17
);
  logic                i_valid;
  logic                o_ready;
  logic [CH*IN_W-1:0]  i_data;
  logic                o_valid;
  logic                i_ready;
  logic [CH*OUT_W-1:0] o_log2;
  logic [CH-1:0]       o_zero;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_log2, o_zero
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_log2, o_zero
  );
endinterface

// File: rtl/log2_lms_pipe.sv
// Three-stage per-channel unsigned log2 (leading-one detect, normalise, table lookup).
// Define LOG2_LMS_INTERP_EN to refine the fraction by linear interpolation between table entries.
module log2_lms_pipe #(
  parameter int CH       = 3,
  parameter int IN_W     = 16,
  parameter int INT_W    = 4,
  parameter int FRAC_W   = 13,
  parameter int LUT_BITS = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  log2_lms_if.slave bus
);
  localparam int OUT_W  = INT_W + FRAC_W;
  localparam int MANT_W = IN_W - 1;
`ifdef LOG2_LMS_INTERP_EN
  localparam int RES_W  = MANT_W - LUT_BITS;
  localparam int PROD_W = FRAC_W + RES_W;
  localparam int KEEP_W = MANT_W;
  localparam int LUT_N  = (2 ** LUT_BITS) + 1;
`else
  localparam int KEEP_W = LUT_BITS;
  localparam int LUT_N  = 2 ** LUT_BITS;
`endif
  localparam int DROP_W = MANT_W - KEEP_W;
  localparam int XF     = 30;
  localparam int GX     = 4;

  // Elaboration-time table entry: log2 of (1 + idx/2^LUT_BITS) by repeated squaring on a
  // XF-bit fixed-point mantissa, GX guard bits, round half up, saturate at the top.
  function automatic logic [FRAC_W-1:0] log2_entry(input int idx);
    logic [63:0] x;
    logic [63:0] acc;
    logic [63:0] rnd;
    logic [FRAC_W-1:0] res;
    x   = 64'(idx + (2 ** LUT_BITS)) << (XF - LUT_BITS);
    acc = 64'd0;
    for (int k = 0; k < FRAC_W + GX; k++) begin
      x   = (x * x) >> XF;
      acc = acc << 1;
      if (x >= (64'd1 << (XF + 1))) begin
        acc = acc | 64'd1;
        x   = x >> 1;
      end else begin
        acc = acc;
      end
    end
    rnd = (acc + (64'd1 << (GX - 1))) >> GX;
    if ((idx >= (2 ** LUT_BITS)) || (rnd >= (64'd1 << FRAC_W))) begin
      res = {FRAC_W{1'b1}};
    end else begin
      res = rnd[FRAC_W-1:0];
    end
    return res;
  endfunction

  logic [FRAC_W-1:0] lut_s [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic [FRAC_W-1:0] ENTRY = log2_entry(g);
    assign lut_s[g] = ENTRY;
  end

  logic                          en1_s, en2_s, en3_s, ready_s, accept_s;
  logic [CH-1:0][INT_W-1:0]      lod_idx_s;
  logic [CH-1:0]                 lod_zero_s;
  logic [CH-1:0][MANT_W-1:0]     data_low_s;
  logic [CH-1:0][KEEP_W-1:0]     norm_s;
  logic [CH-1:0][OUT_W-1:0]      log2_next_s;
  logic [CH-1:0]                 zero_next_s;

  logic                          s1_valid_r, s2_valid_r, out_valid_r;
  logic [CH-1:0][INT_W-1:0]      s1_idx_r, s2_int_r;
  logic [CH-1:0]                 s1_zero_r, s2_zero_r, out_zero_r;
  logic [CH-1:0][MANT_W-1:0]     s1_data_r;
  logic [CH-1:0][KEEP_W-1:0]     s2_mant_r;
  logic [CH-1:0][OUT_W-1:0]      out_log2_r;

  // A stage advances when it is empty or the stage after it advances, so bubbles collapse.
  assign en3_s    = !out_valid_r || bus.i_ready;
  assign en2_s    = !s2_valid_r || en3_s;
  assign en1_s    = !s1_valid_r || en2_s;
  assign ready_s  = i_rst && en3_s;
  assign accept_s = bus.i_valid && ready_s;

  // S1: leading-one index per channel; the highest set bit wins.
  always_comb begin
    lod_idx_s  = {(CH*INT_W){1'b0}};
    lod_zero_s = {CH{1'b0}};
    data_low_s = {(CH*MANT_W){1'b0}};
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < IN_W; k++) begin
        lod_idx_s[c] = bus.i_data[c*IN_W + k] ? INT_W'(k) : lod_idx_s[c];
      end
      lod_zero_s[c] = (bus.i_data[c*IN_W +: IN_W] == {IN_W{1'b0}});
      data_low_s[c] = bus.i_data[c*IN_W +: MANT_W];
    end
  end

  // S2: shifting the bits below the leading one to the top pushes the leading one out.
  always_comb begin
    logic [INT_W-1:0] shamt;
    norm_s = {(CH*KEEP_W){1'b0}};
    shamt  = {INT_W{1'b0}};
    for (int c = 0; c < CH; c++) begin
      shamt     = INT_W'(MANT_W) - s1_idx_r[c];
      norm_s[c] = KEEP_W'((s1_data_r[c] << shamt) >> DROP_W);
    end
  end

  // S3: fraction from the table (optionally interpolated), forced to zero for a zero input.
  always_comb begin
    logic [FRAC_W-1:0] frac;
`ifdef LOG2_LMS_INTERP_EN
    logic [LUT_BITS-1:0] lut_idx;
    logic [LUT_BITS:0]   lut_idx_p1;
    logic [RES_W-1:0]    res;
    logic [FRAC_W-1:0]   lo;
    logic [FRAC_W-1:0]   hi;
    logic [PROD_W-1:0]   prod;
`endif
    log2_next_s = {(CH*OUT_W){1'b0}};
    zero_next_s = {CH{1'b0}};
    frac        = {FRAC_W{1'b0}};
    for (int c = 0; c < CH; c++) begin
`ifdef LOG2_LMS_INTERP_EN
      lut_idx    = s2_mant_r[c][KEEP_W-1 -: LUT_BITS];
      lut_idx_p1 = {1'b0, lut_idx} + {{LUT_BITS{1'b0}}, 1'b1};
      res        = s2_mant_r[c][RES_W-1:0];
      lo         = lut_s[lut_idx];
      hi         = lut_s[lut_idx_p1];
      prod       = PROD_W'(hi - lo) * PROD_W'(res);
      frac       = lo + FRAC_W'(prod >> RES_W);
`else
      frac = lut_s[s2_mant_r[c]];
`endif
      if (s2_zero_r[c]) begin
        log2_next_s[c] = {OUT_W{1'b0}};
      end else begin
        log2_next_s[c] = {s2_int_r[c], frac};
      end
      zero_next_s[c] = s2_zero_r[c] && s2_valid_r;
    end
  end

  // Pipeline registers; each stage holds while the stage after it is full and stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_valid_r  <= 1'b0;
      s2_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      s1_idx_r    <= {(CH*INT_W){1'b0}};
      s1_zero_r   <= {CH{1'b0}};
      s1_data_r   <= {(CH*MANT_W){1'b0}};
      s2_int_r    <= {(CH*INT_W){1'b0}};
      s2_zero_r   <= {CH{1'b0}};
      s2_mant_r   <= {(CH*KEEP_W){1'b0}};
      out_log2_r  <= {(CH*OUT_W){1'b0}};
      out_zero_r  <= {CH{1'b0}};
    end else begin
      if (en1_s) begin
        s1_valid_r <= accept_s;
      end
      if (accept_s) begin
        s1_idx_r  <= lod_idx_s;
        s1_zero_r <= lod_zero_s;
        s1_data_r <= data_low_s;
      end
      if (en2_s) begin
        s2_valid_r <= s1_valid_r;
        s2_int_r   <= s1_idx_r;
        s2_zero_r  <= s1_zero_r;
        s2_mant_r  <= norm_s;
      end
      if (en3_s) begin
        out_valid_r <= s2_valid_r;
        out_log2_r  <= log2_next_s;
        out_zero_r  <= zero_next_s;
      end
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_valid = out_valid_r;
  assign bus.o_log2  = out_log2_r;
  assign bus.o_zero  = out_zero_r;
endmodule

// File: tb/tb_log2_lms_pipe.sv
// Self-checking bench for log2_lms_pipe: directed latency/stall/reset steps plus a random
// stream, all scored against a real-arithmetic log2 model.
`timescale 1ns/1ps
module tb_log2_lms_pipe;
  localparam int CH = 3, IN_W = 16, INT_W = 4, FRAC_W = 13, LUT_BITS = 8;
  localparam int OUT_W = INT_W + FRAC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  log2_lms_if #(.CH(CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  log2_lms_pipe #(.CH(CH), .IN_W(IN_W), .INT_W(INT_W), .FRAC_W(FRAC_W), .LUT_BITS(LUT_BITS))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic [CH*OUT_W-1:0] exp_l_q[$];
  logic [CH-1:0]       exp_z_q[$];
  logic                hold_prev = 1'b0;
  logic [CH*OUT_W-1:0] prev_l;
  logic [CH-1:0]       prev_z;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Table value straight from the definition: round(log2(1+i/256)*8192), saturated.
  function automatic int tval(input int i);
    real v;
    int t;
    v = $ln(1.0 + real'(i) / 256.0) / $ln(2.0) * 8192.0;
    t = int'($floor(v + 0.5));
    if (t > 8191) t = 8191;
    return t;
  endfunction

  function automatic logic [OUT_W-1:0] ref_log2(input int x);
    int e, m, i, r, f;
    logic [3:0]  ei;
    logic [12:0] fi;
    if (x == 0) return '0;
    e = 0;
    while ((x >> (e + 1)) != 0) e++;
    m = (x - (1 << e)) << (15 - e);
    i = m >> 7;
    r = m % 128;
`ifdef LOG2_LMS_INTERP_EN
    f = tval(i) + ((tval(i + 1) - tval(i)) * r) / 128;
`else
    f = tval(i);
    if (r < 0) f = 0;
`endif
    ei = 4'(e);
    fi = 13'(f);
    return {ei, fi};
  endfunction

  function automatic logic [IN_W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'hFFFF;
      3: return 16'd1 << $urandom_range(0, 15);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [CH*IN_W-1:0] pick_beat();
    logic [CH*IN_W-1:0] d;
    for (int c = 0; c < CH; c++) d[c*IN_W +: IN_W] = pick();
    return d;
  endfunction

  // One clock: drive, sample at the falling edge, score, then advance past the rising edge.
  task automatic step(input logic v, input logic [CH*IN_W-1:0] d, input logic rdy,
                      output logic a, output logic f,
                      output logic [CH*OUT_W-1:0] ol, output logic [CH-1:0] oz);
    logic [CH*OUT_W-1:0] el;
    logic [CH-1:0]       ez;
    bus.i_valid = v; bus.i_data = d; bus.i_ready = rdy;
    @(negedge clk);
    a = v && bus.o_ready;
    f = bus.o_valid && rdy;
    ol = bus.o_log2; oz = bus.o_zero;
    if (hold_prev) begin
      chk("hold_valid", 64'(bus.o_valid), 64'd1);
      chk("hold_log2", 64'(bus.o_log2), 64'(prev_l));
      chk("hold_zero", 64'(bus.o_zero), 64'(prev_z));
    end
    if (f) begin
      chk("out_has_expect", 64'(exp_l_q.size() != 0), 64'd1);
      if (exp_l_q.size() != 0) begin
        el = exp_l_q.pop_front();
        ez = exp_z_q.pop_front();
        chk("sb_log2", 64'(bus.o_log2), 64'(el));
        chk("sb_zero", 64'(bus.o_zero), 64'(ez));
      end
    end
    if (a) begin
      for (int c = 0; c < CH; c++) begin
        el[c*OUT_W +: OUT_W] = ref_log2(int'(d[c*IN_W +: IN_W]));
        ez[c] = (d[c*IN_W +: IN_W] == '0);
      end
      exp_l_q.push_back(el);
      exp_z_q.push_back(ez);
    end
    hold_prev = bus.o_valid && !rdy;
    prev_l = bus.o_log2; prev_z = bus.o_zero;
    @(posedge clk); #1;
  endtask

  // Send one beat into an idle pipe and measure the cycles until it emerges.
  task automatic lat_beat(input string tag, input logic [CH*IN_W-1:0] d,
                          output logic [CH*OUT_W-1:0] l, output logic [CH-1:0] z);
    logic a, f;
    logic [CH*OUT_W-1:0] l0;
    logic [CH-1:0] z0;
    int lat;
    l = '0; z = '0;
    step(1'b1, d, 1'b1, a, f, l0, z0);
    chk({tag, "_acc"}, 64'(a), 64'd1);
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      step(1'b0, '0, 1'b1, a, f, l0, z0);
      if (f) begin lat = k; l = l0; z = z0; end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd3);
  endtask

  initial begin
    logic a, f;
    logic [CH*OUT_W-1:0] l;
    logic [CH-1:0] z;
    logic [CH*IN_W-1:0] beats [10];
    int n, outs, cyc, cnt;

    rst = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_log2", 64'(bus.o_log2), 64'd0);
    chk("rst_zero", 64'(bus.o_zero), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;

    lat_beat("ex_8_192_1", {16'd1, 16'd192, 16'd8}, l, z);
    chk("ex_8_192_1_log2", 64'(l), 64'({17'd0, 4'd7, 13'd4792, 4'd3, 13'd0}));
    chk("ex_8_192_1_zero", 64'(z), 64'd0);

    lat_beat("ex_zero_ch1", {16'd255, 16'd0, 16'd255}, l, z);
    chk("ex_zero_ch1_log2", 64'(l), 64'({4'd7, 13'd8146, 17'd0, 4'd7, 13'd8146}));
    chk("ex_zero_ch1_zero", 64'(z), 64'(3'b010));

    lat_beat("ex_max", {3{16'hFFFF}}, l, z);
    for (int c = 0; c < CH; c++) chk("ex_max_int", 64'(l[c*OUT_W + FRAC_W +: INT_W]), 64'd15);

    // Ten-beat stream with the consumer stalled on cycles 4..7.
    for (int i = 0; i < 10; i++) beats[i] = pick_beat();
    n = 0; outs = 0; cyc = 0;
    while ((n < 10 || exp_l_q.size() != 0) && cyc < 60) begin
      step(n < 10, beats[n % 10], !(cyc >= 4 && cyc <= 7), a, f, l, z);
      if (cyc >= 4 && cyc <= 7) chk("stall_ready", 64'(a), 64'd0);
      if (a) n++;
      if (f) outs++;
      cyc++;
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, a, f, l, z);
      if (f) outs++;
    end
    chk("stream_in", 64'(n), 64'd10);
    chk("stream_out", 64'(outs), 64'd10);

    // Reset with two beats in flight: they must vanish.
    step(1'b1, pick_beat(), 1'b1, a, f, l, z);
    chk("flight_acc0", 64'(a), 64'd1);
    step(1'b1, pick_beat(), 1'b1, a, f, l, z);
    chk("flight_acc1", 64'(a), 64'd1);
    rst = 1'b0;
    step(1'b0, '0, 1'b1, a, f, l, z);
    rst = 1'b1;
    exp_l_q.delete(); exp_z_q.delete(); hold_prev = 1'b0;
    step(1'b0, '0, 1'b1, a, f, l, z);
    chk("post_rst_valid", 64'(f), 64'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b1, a, f, l, z);
      if (f) cnt++;
    end
    chk("post_rst_quiet", 64'(cnt), 64'd0);
    lat_beat("after_rst", pick_beat(), l, z);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, pick_beat(), $urandom_range(0, 2) != 0, a, f, l, z);
    for (int k = 0; k < 20 && exp_l_q.size() != 0; k++) step(1'b0, '0, 1'b1, a, f, l, z);
    chk("drain_empty", 64'(exp_l_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
